// File: rtl/fdct_tbuf_ctrl.sv
// Ping-pong transpose buffer sequencer for the FDCT row/column pass (one RAM port).
// Define FDCT_TBUF_TRANSPOSE_EN for column-major readout; otherwise banks read row-major.
module fdct_tbuf_ctrl #(
    parameter int DATA_W = 8,
    parameter int N_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_last,
    output logic                ram_we,
    output logic [2*N_LOG2:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    input  logic [DATA_W-1:0]   ram_dout
);

    localparam int CW = 2 * N_LOG2;
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_MAX = '1;

    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_t;

    logic [1:0]             r_full;
    logic                   r_wbank;
    logic [CW-1:0]          r_wcnt;
    logic                   r_rbank;
    logic [CW-1:0]          r_rcnt;
    prio_t                  r_prio;
    logic [1:0][DATA_W-1:0] r_fd;
    logic [1:0]             r_fl;
    logic                   r_wp;
    logic                   r_rp;
    logic [1:0]             r_cnt;
    logic                   r_inf;
    logic                   r_inf_last;
    logic [CW:0]            r_addr;

    logic                   w_pop;
    logic [2:0]             w_occ;
    logic                   w_r_req;
    logic                   w_w_ok;
    logic                   w_gnt_w;
    logic                   w_gnt_r;
    logic [CW:0]            w_waddr;
    logic [CW:0]            w_raddr;

    assign m_valid = (r_cnt != 2'd0);
    assign m_data  = r_fd[r_rp];
    assign m_last  = m_valid & r_fl[r_rp];
    assign w_pop   = m_valid & m_ready;

    // Credit: FIFO entries plus the read in flight must leave room for one more.
    assign w_occ   = {1'b0, r_cnt} + {2'b0, r_inf} - {2'b0, w_pop};
    assign w_r_req = r_full[r_rbank] & (w_occ < 3'd2);
    assign w_w_ok  = ~r_full[r_wbank];

    assign s_ready = rst_n & w_w_ok & (~w_r_req | (r_prio == PRIO_WR));
    assign w_gnt_w = s_valid & s_ready;
    assign w_gnt_r = w_r_req & ~w_gnt_w;

    assign w_waddr = {r_wbank, r_wcnt};
`ifdef FDCT_TBUF_TRANSPOSE_EN
    assign w_raddr = {r_rbank, r_rcnt[N_LOG2-1:0], r_rcnt[CW-1:N_LOG2]};
`else
    assign w_raddr = {r_rbank, r_rcnt};
`endif

    assign ram_we  = w_gnt_w;
    assign ram_din = s_data;

    always_comb begin
        ram_addr = r_addr;
        if (w_gnt_w) begin
            ram_addr = w_waddr;
        end else if (w_gnt_r) begin
            ram_addr = w_raddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full     <= 2'b00;
            r_wbank    <= 1'b0;
            r_wcnt     <= '0;
            r_rbank    <= 1'b0;
            r_rcnt     <= '0;
            r_prio     <= PRIO_WR;
            r_inf      <= 1'b0;
            r_inf_last <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_addr     <= ram_addr;
            r_inf      <= w_gnt_r;
            r_inf_last <= w_gnt_r & (r_rcnt == C_MAX);
            if (w_gnt_w) begin
                r_wcnt <= r_wcnt + C_ONE;
                if (r_wcnt == C_MAX) begin
                    r_full[r_wbank] <= 1'b1;
                    r_wbank         <= ~r_wbank;
                end
            end
            if (w_gnt_r) begin
                r_rcnt <= r_rcnt + C_ONE;
                if (r_rcnt == C_MAX) begin
                    r_full[r_rbank] <= 1'b0;
                    r_rbank         <= ~r_rbank;
                end
            end
            if (w_gnt_w & w_r_req) begin
                r_prio <= PRIO_RD;
            end else if (w_gnt_r & s_valid & w_w_ok) begin
                r_prio <= PRIO_WR;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fd  <= '0;
            r_fl  <= 2'b00;
            r_wp  <= 1'b0;
            r_rp  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (r_inf) begin
                r_fd[r_wp] <= ram_dout;
                r_fl[r_wp] <= r_inf_last;
                r_wp       <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            unique case ({r_inf, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fdct_tbuf_ctrl.sv
// Directed bench for fdct_tbuf_ctrl with a behavioural 8b x 128 synchronous RAM.
module tb_fdct_tbuf_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
    logic       ram_we;
    logic [6:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [0:127];

    int total = 0;
    int bad = 0;
    int n_rd = 0;
    int n_acc = 0;
    logic [6:0] prev_addr = '0;
    logic [7:0] oq_d [$];
    logic       oq_l [$];
    logic [6:0] wq [$];
    logic       weq [$];

`ifdef FDCT_TBUF_TRANSPOSE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    fdct_tbuf_ctrl #(.DATA_W(8), .N_LOG2(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_addr = '0;
        end else begin
            if (m_valid && m_ready) begin
                oq_d.push_back(m_data);
                oq_l.push_back(m_last);
            end
            if (ram_we) wq.push_back(ram_addr);
            if (s_valid) weq.push_back(ram_we);
            if (!ram_we && ram_addr != prev_addr) n_rd++;
            if (s_valid && s_ready) n_acc++;
            prev_addr = ram_addr;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        oq_d.delete();
        oq_l.delete();
        wq.delete();
        weq.delete();
        n_rd = 0;
        n_acc = 0;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] v);
        int n = 0;
        s_valid = 1'b1;
        s_data = v;
        @(negedge clk);
        while (!s_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n, input string tag);
        int t = 0;
        while (oq_d.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(tag, oq_d.size(), n);
    endtask

    // Expected output j for a run whose first sample value is base.
    function automatic int exp_val(input int base, input int j);
        int blk = j / 64;
        int k = j % 64;
        int idx = TR ? ((k % 8) * 8 + k / 8) : k;
        return (base + blk * 64 + idx) & 255;
    endfunction

    task automatic check_out(input int base, input int n, input string tag);
        for (int j = 0; j < n && j < oq_d.size(); j++) begin
            chk($sformatf("%s_d%0d", tag, j), oq_d[j], exp_val(base, j));
            chk($sformatf("%s_l%0d", tag, j), oq_l[j], (j % 64) == 63);
        end
    endtask

    initial begin
        // 1: reset
        m_ready = 1'b1;
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        do_reset();
        @(negedge clk);
        chk("t1_s_ready", s_ready, 1);
        chk("t1_m_valid", m_valid, 0);
        chk("t1_m_last", m_last, 0);
        chk("t1_m_data", m_data, 0);
        chk("t1_ram_we", ram_we, 0);
        chk("t1_ram_addr", ram_addr, 0);
        @(posedge clk);
        #1;

        // 2: single block and latency
        for (int i = 0; i < 64; i++) send(8'(i));
        s_valid = 1'b0;
        chk("t2_lat0", m_valid, 0);
        @(posedge clk);
        #1;
        chk("t2_lat1", m_valid, 0);
        @(posedge clk);
        #1;
        chk("t2_lat2", m_valid, 1);
        wait_out(64, "t2_cnt");
        check_out(0, 64, "t2");

        // 3: streaming contention
        do_reset();
        for (int i = 0; i < 128; i++) send(8'(i));
        s_valid = 1'b0;
        for (int i = 64; i < 72; i++) begin
            chk($sformatf("t3_we%0d", i), weq[i], (i % 2) == 0);
        end
        wait_out(128, "t3_cnt");
        check_out(0, 128, "t3");
        repeat (20) @(posedge clk);
        chk("t3_no_extra", oq_d.size(), 128);

        // 4: backpressure
        m_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            s_valid = (n_acc < 192);
            s_data = 8'(n_acc);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t4_acc", n_acc, 128);
        chk("t4_s_ready", s_ready, 0);
        chk("t4_m_valid", m_valid, 1);
        chk("t4_m_data", m_data, 0);
        chk("t4_reads", n_rd, 2);
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_out(128, "t4_cnt");
        check_out(0, 128, "t4");

        // 5: reset mid-block
        do_reset();
        for (int i = 0; i < 40; i++) send(8'(100 + i));
        s_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 64; i++) send(8'(200 + i));
        s_valid = 1'b0;
        chk("t5_first_addr", wq[0], 0);
        wait_out(64, "t5_cnt");
        check_out(200, 64, "t5");
        repeat (20) @(posedge clk);
        chk("t5_no_extra", oq_d.size(), 64);

        // 6: four blocks, bank toggling and address wrap
        do_reset();
        for (int i = 0; i < 256; i++) send(8'(i));
        s_valid = 1'b0;
        chk("t6_nw", wq.size(), 256);
        if (wq.size() == 256) begin
            chk("t6_a63", wq[63], 63);
            chk("t6_a64", wq[64], 64);
            chk("t6_a127", wq[127], 127);
            chk("t6_a128", wq[128], 0);
            chk("t6_bank3", wq[192][6], 1);
        end
        wait_out(256, "t6_cnt");
        check_out(0, 256, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
